sysid_timer_regs: RTL and testbench

- Parametrised successor to the system ID peripheral: Avalon-MM slave exposing system ID and build timestamp plus a free-running 64-bit uptime counter, a prescaled tick counter, a control register and a scratch register.
- Sits on the Nios II data master interconnect.
- Lets software verify the hardware build, measure elapsed time and test bus access.

---
 rtl/sysid_timer_regs.sv | 144 ++++++++++++++
 tb/tb_sysid_timer_regs.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_timer_regs.sv
// System ID / build timestamp peripheral with 64-bit uptime, prescaled tick counter,
// control and scratch registers on an Avalon-MM slave with fixed read latency of one.
module sysid_timer_regs #(
    parameter logic [31:0] SYSTEM_ID  = 32'h00000000,
    parameter logic [31:0] TIMESTAMP  = 32'd1456594139,
    parameter int          ADDR_WIDTH = 3,
    parameter int unsigned PRESCALE   = 32'd50000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic [31:0]           readdata,
    output logic                  readdatavalid
);

    localparam logic [31:0] P_TERM = 32'(PRESCALE - 32'd1);

    logic [63:0] r_uptime;
    logic [31:0] r_uptime_hi_snap;
    logic [31:0] r_scratch;
    logic [31:0] r_tick;
    logic [31:0] r_presc;
    logic        r_en;
    logic        r_frz;
    logic [31:0] r_frz_lo;
    logic [31:0] r_frz_hi;
    logic [31:0] r_frz_tick;
    logic [31:0] r_readdata;
    logic        r_readdatavalid;

    logic        w_rd_lo;
    logic        w_wr_scratch;
    logic        w_wr_ctrl;
    logic        w_clr;
    logic        w_frz_rise;
    logic [31:0] w_rdata;

    assign w_rd_lo      = read  && (address == ADDR_WIDTH'(2));
    assign w_wr_scratch = write && (address == ADDR_WIDTH'(4));
    assign w_wr_ctrl    = write && (address == ADDR_WIDTH'(5)) && byteenable[0];
    assign w_clr        = w_wr_ctrl && writedata[1];
    assign w_frz_rise   = w_wr_ctrl && writedata[2] && !r_frz;

    // Read mux over current (pre-write) register contents
    always_comb begin
        w_rdata = 32'd0;
        case (address)
            ADDR_WIDTH'(0): w_rdata = SYSTEM_ID;
            ADDR_WIDTH'(1): w_rdata = TIMESTAMP;
            ADDR_WIDTH'(2): w_rdata = r_frz ? r_frz_lo : r_uptime[31:0];
            ADDR_WIDTH'(3): w_rdata = r_uptime_hi_snap;
            ADDR_WIDTH'(4): w_rdata = r_scratch;
            ADDR_WIDTH'(5): w_rdata = {29'd0, r_frz, 1'b0, r_en};
            ADDR_WIDTH'(6): w_rdata = r_frz ? r_frz_tick : r_tick;
            ADDR_WIDTH'(7): w_rdata = PRESCALE;
            default:        w_rdata = 32'd0;
        endcase
    end

    // Registered read response, one cycle after the strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readdata      <= 32'd0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= read;
            if (read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    // Uptime, prescaler and tick counters; a CLR write beats an increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_uptime <= 64'd0;
            r_presc  <= 32'd0;
            r_tick   <= 32'd0;
        end else if (w_clr) begin
            r_uptime <= 64'd0;
            r_presc  <= 32'd0;
            r_tick   <= 32'd0;
        end else if (r_en) begin
            r_uptime <= r_uptime + 64'd1;
            if (r_presc == P_TERM) begin
                r_presc <= 32'd0;
                r_tick  <= r_tick + 32'd1;
            end else begin
                r_presc <= r_presc + 32'd1;
            end
        end
    end

    // Control bits and freeze capture on the FRZ rising write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_en       <= 1'b1;
            r_frz      <= 1'b0;
            r_frz_lo   <= 32'd0;
            r_frz_hi   <= 32'd0;
            r_frz_tick <= 32'd0;
        end else begin
            if (w_frz_rise) begin
                r_frz_lo   <= r_uptime[31:0];
                r_frz_hi   <= r_uptime[63:32];
                r_frz_tick <= r_tick;
            end
            if (w_wr_ctrl) begin
                r_en  <= writedata[0];
                r_frz <= writedata[2];
            end
        end
    end

    // HI snapshot taken by a LO read keeps LO/HI pairs coherent
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_uptime_hi_snap <= 32'd0;
        end else if (w_rd_lo) begin
            r_uptime_hi_snap <= r_frz ? r_frz_hi : r_uptime[63:32];
        end
    end

    // Byte-lane scratch register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scratch <= 32'd0;
        end else if (w_wr_scratch) begin
            for (int k = 0; k < 4; k++) begin
                if (byteenable[k]) begin
                    r_scratch[8*k +: 8] <= writedata[8*k +: 8];
                end
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_timer_regs.sv
// Directed plus random bus traffic against an elapsed-cycle reference model of the peripheral.
module tb_sysid_timer_regs;

    localparam logic [31:0] SID = 32'hCAFE0001;
    localparam logic [31:0] TS  = 32'd1456594139;
    localparam int          AW  = 4;
    localparam int          P   = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = 32'd0;
    logic [3:0]    byteenable = 4'd0;
    logic [31:0]   readdata;
    logic          readdatavalid;

    int errors = 0;
    int checks = 0;

    // model: uptime value, enabled cycles since last clear (tick = cycles / P)
    logic [63:0] m_up;
    logic [63:0] m_cnt;
    logic [31:0] m_snap, m_scr, m_flo, m_fhi, m_ftick;
    bit          m_en, m_frz;
    logic [31:0] last;
    logic [31:0] lo1;

    sysid_timer_regs #(
        .SYSTEM_ID (SID),
        .TIMESTAMP (TS),
        .ADDR_WIDTH(AW),
        .PRESCALE  (P)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .readdata     (readdata),
        .readdatavalid(readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_up = 64'd0; m_cnt = 64'd0; m_snap = 32'd0; m_scr = 32'd0;
        m_flo = 32'd0; m_fhi = 32'd0; m_ftick = 32'd0;
        m_en = 1'b1; m_frz = 1'b0;
    endtask

    function automatic logic [31:0] m_tick();
        return 32'(m_cnt / 64'(P));
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        case (a)
            4'd0:    return SID;
            4'd1:    return TS;
            4'd2:    return m_frz ? m_flo : m_up[31:0];
            4'd3:    return m_snap;
            4'd4:    return m_scr;
            4'd5:    return {29'd0, m_frz, 1'b0, m_en};
            4'd6:    return m_frz ? m_ftick : m_tick();
            4'd7:    return 32'(P);
            default: return 32'd0;
        endcase
    endfunction

    task automatic cyc(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input string tag);
        logic [31:0] exp;
        bit          ctrl_wr;
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        exp = model_read(a);
        ctrl_wr = wr && (a == 4'd5) && be[0];
        @(posedge clock);
        if (rd && a == 4'd2) m_snap = m_frz ? m_fhi : m_up[63:32];
        if (wr && a == 4'd4)
            for (int k = 0; k < 4; k++) if (be[k]) m_scr[8*k +: 8] = wd[8*k +: 8];
        if (ctrl_wr && wd[2] && !m_frz) begin
            m_flo = m_up[31:0]; m_fhi = m_up[63:32]; m_ftick = m_tick();
        end
        if (ctrl_wr && wd[1]) begin
            m_up = 64'd0; m_cnt = 64'd0;
        end else if (m_en) begin
            m_up = m_up + 64'd1; m_cnt = m_cnt + 64'd1;
        end
        if (ctrl_wr) begin
            m_en = wd[0]; m_frz = wd[2];
        end
        #1;
        check({tag, "_valid"}, {31'd0, readdatavalid}, {31'd0, rd});
        if (rd) check(tag, readdata, exp);
        last = readdata;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, "idle");
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        cyc(1'b1, 1'b0, a, 32'd0, 4'd0, tag);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b0, 1'b1, a, d, be, "wr");
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #4 reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [31:0]   d;
        model_reset();
        last = 32'd0;
        #12;
        check("rst_valid", {31'd0, readdatavalid}, 32'd0);
        check("rst_data", readdata, 32'd0);
        #11 reset = 1'b0;

        rd(4'd0, "id"); idle(1);
        rd(4'd1, "tstamp"); idle(1);
        rd(4'd7, "caps");
        check("caps_const", last, 32'd4);
        rd(4'd9, "unmapped");
        rd(4'd3, "hi_before_lo");

        wr(4'd4, 32'hFFFFFFFF, 4'b1111);
        wr(4'd4, 32'h12345678, 4'b0101);
        rd(4'd4, "scratch");
        check("scratch_const", last, 32'hFF34FF78);
        wr(4'd0, 32'hDEADBEEF, 4'b1111);
        rd(4'd0, "id_ro");

        do_reset();
        idle(40);
        rd(4'd6, "tick40");
        check("tick40_const", last, 32'd10);
        wr(4'd5, 32'd0, 4'b0001);
        idle(20);
        rd(4'd6, "tick_held");
        check("tick_held_const", last, 32'd10);
        wr(4'd5, 32'd1, 4'b0001);
        idle(12);
        rd(4'd6, "tick_resume");
        check("tick_resume_gt", {31'd0, last > 32'd10}, 32'd1);

        wr(4'd5, 32'd3, 4'b0001);
        rd(4'd2, "clr_lo");
        check("clr_lo_small", {31'd0, last < 32'd3}, 32'd1);
        rd(4'd6, "clr_tick");
        check("clr_tick_zero", last, 32'd0);
        rd(4'd5, "clr_ctrl");
        check("clr_ctrl_one", last, 32'd1);

        force dut.r_uptime = 64'h00000000_FFFFFFFE;
        m_up = 64'h00000000_FFFFFFFE;
        #1 release dut.r_uptime;
        rd(4'd2, "wrap_lo");
        check("wrap_lo_const", last, 32'hFFFFFFFE);
        rd(4'd3, "wrap_hi");
        check("wrap_hi_const", last, 32'd0);
        rd(4'd2, "wrap_lo2");
        rd(4'd3, "wrap_hi2");

        wr(4'd5, 32'd5, 4'b0001);
        idle(5);
        rd(4'd2, "frz_lo");
        lo1 = last;
        rd(4'd6, "frz_tick");
        rd(4'd3, "frz_hi");
        wr(4'd5, 32'd7, 4'b0001);
        idle(3);
        rd(4'd2, "frz_lo_after_clr");
        check("frz_hold", last, lo1);
        rd(4'd5, "frz_ctrl");
        wr(4'd5, 32'd1, 4'b1110);
        rd(4'd5, "ctrl_be0_only");
        wr(4'd5, 32'd1, 4'b0001);
        rd(4'd2, "unfrz_lo");
        rd(4'd6, "unfrz_tick");

        for (int i = 0; i < 300; i++) begin
            a = AW'($urandom_range(0, 15));
            d = $urandom;
            if (a == 4'd5) d[0] = ($urandom_range(0, 3) != 0);
            if (a == 4'd5) d[1] = ($urandom_range(0, 7) == 0);
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, d,
                4'($urandom), "rand");
        end

        read = 1'b1; address = 4'd4;
        @(posedge clock);
        #1 read = 1'b0;
        check("pre_rst_valid", {31'd0, readdatavalid}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, readdatavalid}, 32'd0);
        check("async_rst_data", readdata, 32'd0);
        model_reset();
        #2 reset = 1'b0;
        rd(4'd4, "post_rst_scratch");
        check("post_rst_scratch_const", last, 32'd0);
        rd(4'd5, "post_rst_ctrl");
        check("post_rst_ctrl_const", last, 32'd1);
        rd(4'd3, "post_rst_hi");
        rd(4'd6, "post_rst_tick");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
